timer_btn_cond: RTL and testbench

TIMER_BTN_COND -- requirements
Module: timer_btn_cond

---
 rtl/timer_btn_cond.sv | 124 ++++++++++++
 tb/tb_timer_btn_cond.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_btn_cond.sv
// timer_btn_cond: three-channel button conditioner (sync, debounce, press/release/long-press pulses).
// Define TIMER_BTN_LONG_PRESS_EN to build the per-channel long-press hold counters.
`default_nettype none

module timer_btn_cond #(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int LONG_CYCLES     = 10000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [2:0] btn_raw,
   output logic [2:0] btn_level,
   output logic [2:0] press_pulse,
   output logic [2:0] release_pulse,
   output logic [2:0] long_pulse,
   output logic       any_press
);

   localparam int              DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
`ifdef TIMER_BTN_LONG_PRESS_EN
   localparam int                HOLD_W   = $clog2(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);
`endif

   logic [2:0] sync_a;
   logic [2:0] sync_b;

   // Synchronisers keep sampling while ena is low so a held button is seen on re-enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_ch
      logic [DB_W-1:0] db_cnt;
      logic            level;
      logic            level_q;
      logic            press_q;
      logic            release_q;
      logic            differ;

      assign differ = sync_b[i] ^ level;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            db_cnt    <= '0;
            level     <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else if (!ena) begin
            db_cnt    <= '0;
            level     <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            if (!differ) begin
               db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
               db_cnt <= '0;
               level  <= ~level;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
            level_q   <= level;
            press_q   <= level & ~level_q;
            release_q <= ~level & level_q;
         end
      end

      assign btn_level[i]     = level;
      assign press_pulse[i]   = press_q;
      assign release_pulse[i] = release_q;

`ifdef TIMER_BTN_LONG_PRESS_EN
      logic [HOLD_W-1:0] hold_cnt;
      logic              long_done;
      logic              long_q;

      // Hold count restarts on the first high cycle, saturates, and fires once per press.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
            long_q    <= 1'b0;
         end else if (!ena) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
            long_q    <= 1'b0;
         end else begin
            long_q <= 1'b0;
            if (!level) begin
               hold_cnt  <= '0;
               long_done <= 1'b0;
            end else if (!level_q) begin
               hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
               hold_cnt <= hold_cnt + 1'b1;
            end else if (!long_done) begin
               long_q    <= 1'b1;
               long_done <= 1'b1;
            end
         end
      end

      assign long_pulse[i] = long_q;
`else
      assign long_pulse[i] = 1'b0;
`endif
   end

   assign any_press = |press_pulse;

endmodule

`default_nettype wire

// File: tb/tb_timer_btn_cond.sv
// tb_timer_btn_cond: scoreboard bench for timer_btn_cond with DEBOUNCE_CYCLES=8, LONG_CYCLES=32.
`default_nettype none

module tb_timer_btn_cond;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [2:0] btn_raw;
   logic [2:0] btn_level;
   logic [2:0] press_pulse;
   logic [2:0] release_pulse;
   logic [2:0] long_pulse;
   logic       any_press;

   timer_btn_cond #(
      .DEBOUNCE_CYCLES(8),
      .LONG_CYCLES    (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .btn_raw      (btn_raw),
      .btn_level    (btn_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse),
      .any_press    (any_press)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [2:0] p;
      logic [2:0] r;
      logic [2:0] l;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int c, input logic [2:0] p, input logic [2:0] r, input logic [2:0] l);
      exp_t e;
      e.cyc = c;
      e.p   = p;
      e.r   = r;
      e.l   = l;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every nonzero pulse pattern must match the head of the scoreboard at its cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0 && sb[0].cyc < cyc) begin
         checks++;
         errors++;
         e = sb.pop_front();
         $display("FAIL missing_pulse: got none expected p=%b r=%b l=%b at cycle %0d", e.p, e.r, e.l, e.cyc);
      end
      if ((press_pulse | release_pulse | long_pulse) != 3'b000 || any_press) begin
         checks++;
         if (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            if (press_pulse !== e.p || release_pulse !== e.r || long_pulse !== e.l || any_press !== (|e.p)) begin
               errors++;
               $display("FAIL pulse_cmp: got p=%b r=%b l=%b any=%b expected p=%b r=%b l=%b any=%b at cycle %0d",
                        press_pulse, release_pulse, long_pulse, any_press, e.p, e.r, e.l, |e.p, cyc);
            end
         end else begin
            errors++;
            $display("FAIL unexpected_pulse: got p=%b r=%b l=%b any=%b expected none at cycle %0d",
                     press_pulse, release_pulse, long_pulse, any_press, cyc);
         end
      end
   end

   initial begin
      int base;
      rst_n   = 1'b0;
      ena     = 1'b1;
      btn_raw = 3'b000;

      step(3);
      chk("rst_level",   btn_level,     0);
      chk("rst_press",   press_pulse,   0);
      chk("rst_release", release_pulse, 0);
      chk("rst_long",    long_pulse,    0);
      chk("rst_any",     any_press,     0);
      rst_n = 1'b1;
      step(5);

      // Clean press on channel 0, held 40 clocks
      base = cyc;
      btn_raw = 3'b001;
      push(base + 11, 3'b001, 3'b000, 3'b000);
`ifdef TIMER_BTN_LONG_PRESS_EN
      push(base + 43, 3'b000, 3'b000, 3'b001);
`endif
      step(9);
      chk("clean_level_pre", btn_level, 3'b000);
      step(1);
      chk("clean_level", btn_level, 3'b001);
      step(30);
      btn_raw = 3'b000;
      push(base + 51, 3'b000, 3'b001, 3'b000);
      step(20);

      // Bouncing channel 1: toggles every 3 clocks for 30 clocks, then stable high
      base = cyc;
      for (int k = 0; k < 10; k++) begin
         btn_raw[1] = (k % 2 == 0);
         step(3);
      end
      btn_raw[1] = 1'b1;
      push(base + 41, 3'b010, 3'b000, 3'b000);
      step(9);
      chk("bounce_level_pre", btn_level, 3'b000);
      step(11);
      btn_raw[1] = 1'b0;
      push(base + 61, 3'b000, 3'b010, 3'b000);
      step(20);

      // Simultaneous press and release on all channels
      base = cyc;
      btn_raw = 3'b111;
      push(base + 11, 3'b111, 3'b000, 3'b000);
      step(10);
      chk("all_level", btn_level, 3'b111);
      step(5);
      btn_raw = 3'b000;
      push(base + 26, 3'b000, 3'b111, 3'b000);
      step(20);

      // Long hold on channel 2 (60 clocks), then a short hold (20 clocks)
      base = cyc;
      btn_raw = 3'b100;
      push(base + 11, 3'b100, 3'b000, 3'b000);
`ifdef TIMER_BTN_LONG_PRESS_EN
      push(base + 43, 3'b000, 3'b000, 3'b100);
`endif
      step(60);
      btn_raw = 3'b000;
      push(base + 71, 3'b000, 3'b100, 3'b000);
      step(20);
      base = cyc;
      btn_raw = 3'b100;
      push(base + 11, 3'b100, 3'b000, 3'b000);
      step(20);
      btn_raw = 3'b000;
      push(base + 31, 3'b000, 3'b100, 3'b000);
      step(20);

      // Reset mid-debounce (count 5), then ena dropped mid-hold
      base = cyc;
      btn_raw = 3'b001;
      step(7);
      rst_n = 1'b0;
      #1;
      chk("midrst_level", btn_level, 0);
      chk("midrst_press", press_pulse, 0);
      chk("midrst_any",   any_press, 0);
      step(2);
      rst_n = 1'b1;
      push(base + 20, 3'b001, 3'b000, 3'b000);
      step(9);
      chk("rerst_level_pre", btn_level, 3'b000);
      step(1);
      chk("rerst_level", btn_level, 3'b001);
      step(11);
      ena = 1'b0;
      step(1);
      chk("ena_low_level", btn_level, 3'b000);
      chk("ena_low_long",  long_pulse, 3'b000);
      step(4);
      ena = 1'b1;
      push(base + 44, 3'b001, 3'b000, 3'b000);
      step(7);
      chk("ena_re_level_pre", btn_level, 3'b000);
      step(1);
      chk("ena_re_level", btn_level, 3'b001);
      step(7);
      btn_raw = 3'b000;
      push(base + 61, 3'b000, 3'b001, 3'b000);
      step(25);

      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
